// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, issues one req/ack read at a time and
// presents each fetched word with its PC to decode over a valid/ready handshake.
module fetch_sequencer #(
   parameter int unsigned        ADDR_W   = 32,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Fetch_En,
   input  logic               Redirect_Valid,
   input  logic [ADDR_W-1:0]  Redirect_PC,
   output logic               Mem_Req,
   output logic [ADDR_W-1:0]  Mem_Addr,
   input  logic               Mem_Ack,
   input  logic [INSTR_W-1:0] Mem_Rdata,
   output logic               Instr_Valid,
   input  logic               Instr_Ready,
   output logic [INSTR_W-1:0] Instr_Code,
   output logic [ADDR_W-1:0]  Instr_PC,
   output logic [ADDR_W-1:0]  Fetch_PC
);

   typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

   state_e             state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  hold_addr_q;
   logic               squash_q;
   logic               mem_req_q;
   logic               instr_valid_q;
   logic [INSTR_W-1:0] instr_code_q;
   logic [ADDR_W-1:0]  instr_pc_q;
   logic [ADDR_W-1:0]  redirect_tgt;

   assign redirect_tgt = {Redirect_PC[ADDR_W-1:2], 2'b00};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         hold_addr_q   <= RESET_PC;
         squash_q      <= 1'b0;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_code_q  <= '0;
         instr_pc_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (Redirect_Valid) pc_q <= redirect_tgt;
               if (Fetch_En) begin
                  state_q   <= StReq;
                  mem_req_q <= 1'b1;
               end
            end
            StReq: begin
               if (Mem_Ack) begin
                  if (squash_q || Redirect_Valid) begin
                     // Returned word belongs to a dead stream; reissue at the current PC.
                     squash_q <= 1'b0;
                     if (Redirect_Valid) pc_q <= redirect_tgt;
                  end else begin
                     instr_code_q  <= Mem_Rdata;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                     pc_q          <= pc_q + ADDR_W'(4);
                     mem_req_q     <= 1'b0;
                     state_q       <= StHold;
                  end
               end else if (Redirect_Valid) begin
                  // Keep presenting the in-flight address; a repeat redirect must not clobber it.
                  if (!squash_q) hold_addr_q <= pc_q;
                  squash_q <= 1'b1;
                  pc_q     <= redirect_tgt;
               end
            end
            StHold: begin
               if (Redirect_Valid) begin
                  instr_valid_q <= 1'b0;
                  pc_q          <= redirect_tgt;
                  mem_req_q     <= 1'b1;
                  state_q       <= StReq;
               end else if (Instr_Ready) begin
                  instr_valid_q <= 1'b0;
                  mem_req_q     <= 1'b1;
                  state_q       <= StReq;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign Mem_Req     = mem_req_q;
   assign Mem_Addr    = squash_q ? hold_addr_q : pc_q;
   assign Instr_Valid = instr_valid_q;
   assign Instr_Code  = instr_code_q;
   assign Instr_PC    = instr_pc_q;
   assign Fetch_PC    = pc_q;

endmodule
